// File: rtl/tlu_trigger_sequencer_if.sv
// Event-level signals between the trigger sequencer, the TLU handshake block,
// the readout engine and the DAQ header stream.
interface tlu_trigger_sequencer_if;
    logic        TRIGGER_VALID;
    logic        TRIGGER_CNT_VALID;
    logic [15:0] TRIGGER_CNT;
    logic        HOLD_BUSY;
    logic        RDO_START;
    logic        RDO_DONE;
    logic [31:0] EVT_DATA;
    logic        EVT_VALID;
    logic        EVT_READY;

    modport master (
        input  TRIGGER_VALID, TRIGGER_CNT_VALID, TRIGGER_CNT, RDO_DONE, EVT_READY,
        output HOLD_BUSY, RDO_START, EVT_DATA, EVT_VALID
    );

    modport slave (
        output TRIGGER_VALID, TRIGGER_CNT_VALID, TRIGGER_CNT, RDO_DONE, EVT_READY,
        input  HOLD_BUSY, RDO_START, EVT_DATA, EVT_VALID
    );
endinterface

// File: rtl/tlu_trigger_sequencer.sv
// Per-trigger sequencer: captures the TLU trigger number, checks continuity,
// emits a two-word event header, runs readout and extends BUSY until it ends.
module tlu_trigger_sequencer #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
    parameter logic [15:0] HDR_MARKER     = 16'hEB90
) (
    input  logic                            CLK,
    input  logic                            RST_SYS,
    input  logic                            EN,
    input  logic                            CLR_ERR,
    tlu_trigger_sequencer_if.master         bus,
    output logic [15:0]                     TRIG_EXPECTED,
    output logic [31:0]                     EVT_COUNT,
    output logic                            ERR_SEQ,
    output logic                            ERR_TIMEOUT
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_CNT = 3'd1;
    localparam logic [2:0] S_HDR0     = 3'd2;
    localparam logic [2:0] S_HDR1     = 3'd3;
    localparam logic [2:0] S_READOUT  = 3'd4;
    localparam logic [2:0] S_GAP      = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [31:0] ts_q;
    logic [31:0] ts_lat_q, ts_lat_d;
    logic [15:0] tmo_q, tmo_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] exp_q, exp_d;
    logic [31:0] evt_cnt_q, evt_cnt_d;
    logic        sync_q, sync_d;
    logic        err_seq_q, err_seq_d;
    logic        err_tmo_q, err_tmo_d;
    logic        rdo_start_q, rdo_start_d;
    logic        en_q;
    logic        seq_set, tmo_set, tmo_last;

    assign tmo_last = (tmo_q == (TIMEOUT_CYCLES - 16'd1));

    always_comb begin
        state_d     = state_q;
        ts_lat_d    = ts_lat_q;
        tmo_d       = tmo_q;
        cnt_d       = cnt_q;
        exp_d       = exp_q;
        evt_cnt_d   = evt_cnt_q;
        sync_d      = sync_q;
        rdo_start_d = 1'b0;
        seq_set     = 1'b0;
        tmo_set     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (EN && bus.TRIGGER_VALID) begin
                    state_d  = S_WAIT_CNT;
                    ts_lat_d = ts_q;
                    tmo_d    = 16'd0;
                end
            end
            S_WAIT_CNT: begin
                if (bus.TRIGGER_CNT_VALID) begin
                    cnt_d = bus.TRIGGER_CNT;
                    // First number after (re)sync only seeds the expectation.
                    if (sync_q) begin
                        sync_d = 1'b0;
                    end else if (bus.TRIGGER_CNT != exp_q) begin
                        seq_set = 1'b1;
                    end
                    exp_d   = bus.TRIGGER_CNT + 16'd1;
                    state_d = S_HDR0;
                end else if (tmo_last) begin
                    tmo_set = 1'b1;
                    sync_d  = 1'b1;
                    state_d = S_GAP;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_HDR0: begin
                if (bus.EVT_READY) state_d = S_HDR1;
            end
            S_HDR1: begin
                if (bus.EVT_READY) begin
                    state_d     = S_READOUT;
                    tmo_d       = 16'd0;
                    rdo_start_d = 1'b1;
                end
            end
            S_READOUT: begin
                if (bus.RDO_DONE) begin
                    evt_cnt_d = evt_cnt_q + 32'd1;
                    state_d   = S_GAP;
                end else if (tmo_last) begin
                    tmo_set = 1'b1;
                    state_d = S_GAP;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_GAP: begin
                if (!bus.TRIGGER_VALID) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (EN && !en_q) sync_d = 1'b1;
        // A new error in the clearing cycle must survive.
        err_seq_d = seq_set | (err_seq_q & ~CLR_ERR);
        err_tmo_d = tmo_set | (err_tmo_q & ~CLR_ERR);
    end

    always_ff @(posedge CLK) begin
        if (RST_SYS) begin
            state_q     <= S_IDLE;
            ts_q        <= 32'd0;
            ts_lat_q    <= 32'd0;
            tmo_q       <= 16'd0;
            cnt_q       <= 16'd0;
            exp_q       <= 16'd0;
            evt_cnt_q   <= 32'd0;
            sync_q      <= 1'b1;
            err_seq_q   <= 1'b0;
            err_tmo_q   <= 1'b0;
            rdo_start_q <= 1'b0;
            en_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            ts_q        <= ts_q + 32'd1;
            ts_lat_q    <= ts_lat_d;
            tmo_q       <= tmo_d;
            cnt_q       <= cnt_d;
            exp_q       <= exp_d;
            evt_cnt_q   <= evt_cnt_d;
            sync_q      <= sync_d;
            err_seq_q   <= err_seq_d;
            err_tmo_q   <= err_tmo_d;
            rdo_start_q <= rdo_start_d;
            en_q        <= EN;
        end
    end

    always_comb begin
        case (state_q)
            S_HDR0:  bus.EVT_DATA = {HDR_MARKER, cnt_q};
            S_HDR1:  bus.EVT_DATA = ts_lat_q;
            default: bus.EVT_DATA = 32'd0;
        endcase
    end

    assign bus.EVT_VALID  = (state_q == S_HDR0) || (state_q == S_HDR1);
    assign bus.HOLD_BUSY  = (state_q == S_IDLE) ? ~EN : 1'b1;
    assign bus.RDO_START  = rdo_start_q;
    assign TRIG_EXPECTED  = exp_q;
    assign EVT_COUNT      = evt_cnt_q;
    assign ERR_SEQ        = err_seq_q;
    assign ERR_TIMEOUT    = err_tmo_q;

endmodule
